// File: rtl/vga_draw_arbiter_if.sv
// rtl/vga_draw_arbiter_if.sv - requester and pixel-port bundle for vga_draw_arbiter
//
// Groups the request side (req, req_x, req_y, req_colour), the handshake back to the
// sprite engines (grant, done, busy) and the pixel-write port to vga_adapter
// (vga_x, vga_y, vga_colour, vga_plot).
//   master : the game side, drives requests and observes grant/done/busy/pixels
//   slave  : the arbiter, consumes requests and drives everything else
// Requester i uses req_x[8i+7:8i], req_y[7i+6:7i] and req_colour[3i+2:3i].

interface vga_draw_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_x;
    logic [7*NUM_REQ-1:0] req_y;
    logic [3*NUM_REQ-1:0] req_colour;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   done;
    logic                 busy;
    logic [7:0]           vga_x;
    logic [6:0]           vga_y;
    logic [2:0]           vga_colour;
    logic                 vga_plot;

    modport master (
        output req, req_x, req_y, req_colour,
        input  grant, done, busy, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  req, req_x, req_y, req_colour,
        output grant, done, busy, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/vga_draw_arbiter.sv
// rtl/vga_draw_arbiter.sv - round-robin arbiter scanning sprite rectangles onto vga_adapter
//
// Shares the single vga_adapter pixel-write port among NUM_REQ sprite engines. In IDLE
// the first pending requester at or above the round-robin pointer (with wrap) wins; its
// BOX_W x BOX_H rectangle is then emitted one pixel per clock in row-major order, with
// pixels past SCREEN_W / SCREEN_H suppressed (cycle still spent). A one-cycle done pulse
// closes the service and the pointer moves just past the winner.
// Ports:
//   CLOCK_50 : system clock, rising edge
//   reset    : asynchronous, active-high
//   bus      : vga_draw_arbiter_if.slave - req/req_x/req_y/req_colour in;
//              grant/done/busy and vga_x/vga_y/vga_colour/vga_plot out (all registered)

module vga_draw_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int BOX_W    = 4,
    parameter int BOX_H    = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input logic               CLOCK_50,
    input logic               reset,
    vga_draw_arbiter_if.slave bus
);
    localparam int                 RR_W     = $clog2(NUM_REQ);
    localparam logic [3:0]         LAST_COL = 4'(BOX_W - 1);
    localparam logic [3:0]         LAST_ROW = 4'(BOX_H - 1);
    localparam logic [8:0]         CLIP_X   = 9'(SCREEN_W);
    localparam logic [7:0]         CLIP_Y   = 8'(SCREEN_H);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    logic [RR_W-1:0]     rr_ptr;
    logic [RR_W-1:0]     cur_idx;
    logic [7:0]          base_x;
    logic [6:0]          base_y;
    logic [2:0]          base_colour;
    logic [3:0]          col;
    logic [3:0]          row;

    logic [NUM_REQ-1:0]  grant_r;
    logic [NUM_REQ-1:0]  done_r;
    logic                busy_r;
    logic [7:0]          vga_x_r;
    logic [6:0]          vga_y_r;
    logic [2:0]          vga_colour_r;
    logic                vga_plot_r;

    // Round-robin search: first set request bit starting at rr_ptr, wrapping around.
    logic                found;
    logic [RR_W-1:0]     pick;
    int                  scan_idx;

    always_comb begin
        found    = 1'b0;
        pick     = '0;
        scan_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && bus.req[scan_idx]) begin
                found = 1'b1;
                pick  = RR_W'(scan_idx);
            end
        end
    end

    logic [7:0] cand_x;
    logic [6:0] cand_y;
    logic [2:0] cand_colour;

    assign cand_x      = bus.req_x[8*int'(pick) +: 8];
    assign cand_y      = bus.req_y[7*int'(pick) +: 7];
    assign cand_colour = bus.req_colour[3*int'(pick) +: 3];

    // Next pixel to present. Outputs are registered, so pixel 0 is loaded on the
    // arbitration edge straight from the winner's inputs; later pixels come from the
    // latched base plus the advanced column/row.
    logic       last_px;
    logic [3:0] nxt_col;
    logic [3:0] nxt_row;
    logic [7:0] src_x;
    logic [6:0] src_y;
    logic [3:0] off_c;
    logic [3:0] off_r;
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       px_visible;

    always_comb begin
        last_px = (col == LAST_COL) && (row == LAST_ROW);
        if (col == LAST_COL) begin
            nxt_col = '0;
            nxt_row = row + 4'd1;
        end else begin
            nxt_col = col + 4'd1;
            nxt_row = row;
        end
        if (state == S_IDLE) begin
            src_x = cand_x;
            src_y = cand_y;
            off_c = '0;
            off_r = '0;
        end else begin
            src_x = base_x;
            src_y = base_y;
            off_c = nxt_col;
            off_r = nxt_row;
        end
        // One bit wider so pixels past the right/bottom edge clip rather than wrap.
        sum_x      = {1'b0, src_x} + {5'b0, off_c};
        sum_y      = {1'b0, src_y} + {4'b0, off_r};
        px_visible = (sum_x < CLIP_X) && (sum_y < CLIP_Y);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            cur_idx      <= '0;
            base_x       <= '0;
            base_y       <= '0;
            base_colour  <= '0;
            col          <= '0;
            row          <= '0;
            grant_r      <= '0;
            done_r       <= '0;
            busy_r       <= 1'b0;
            vga_x_r      <= '0;
            vga_y_r      <= '0;
            vga_colour_r <= '0;
            vga_plot_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_r     <= '0;
                    vga_plot_r <= 1'b0;
                    if (found) begin
                        cur_idx      <= pick;
                        base_x       <= cand_x;
                        base_y       <= cand_y;
                        base_colour  <= cand_colour;
                        col          <= '0;
                        row          <= '0;
                        grant_r      <= ONE_HOT0 << pick;
                        busy_r       <= 1'b1;
                        vga_x_r      <= sum_x[7:0];
                        vga_y_r      <= sum_y[6:0];
                        vga_colour_r <= cand_colour;
                        vga_plot_r   <= px_visible;
                        state        <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (last_px) begin
                        vga_plot_r <= 1'b0;
                        grant_r    <= '0;
                        done_r     <= ONE_HOT0 << cur_idx;
                        state      <= S_DONE;
                    end else begin
                        col          <= nxt_col;
                        row          <= nxt_row;
                        vga_x_r      <= sum_x[7:0];
                        vga_y_r      <= sum_y[6:0];
                        vga_colour_r <= base_colour;
                        vga_plot_r   <= px_visible;
                    end
                end
                S_DONE: begin
                    done_r     <= '0;
                    busy_r     <= 1'b0;
                    vga_plot_r <= 1'b0;
                    // The just-served requester drops to lowest priority.
                    rr_ptr     <= (cur_idx == RR_W'(NUM_REQ - 1)) ? '0 : cur_idx + 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    grant_r    <= '0;
                    done_r     <= '0;
                    busy_r     <= 1'b0;
                    vga_plot_r <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant      = grant_r;
    assign bus.done       = done_r;
    assign bus.busy       = busy_r;
    assign bus.vga_x      = vga_x_r;
    assign bus.vga_y      = vga_y_r;
    assign bus.vga_colour = vga_colour_r;
    assign bus.vga_plot   = vga_plot_r;
endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb/tb_vga_draw_arbiter.sv - self-checking bench for vga_draw_arbiter

module tb_vga_draw_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int BOX_W    = 4;
    localparam int BOX_H    = 4;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int NPIX     = BOX_W * BOX_H;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    bit   chk_en   = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    vga_draw_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    vga_draw_arbiter #(
        .NUM_REQ(NUM_REQ), .BOX_W(BOX_W), .BOX_H(BOX_H),
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a service is a numbered sequence of cycles; cycle k < NPIX shows
    // pixel k of the latched rectangle, cycle NPIX is the done cycle, then it is idle.
    bit   m_act;
    int   m_t;
    int   m_win;
    int   m_next;
    int   m_bx, m_by;
    int   m_col;

    always @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            m_act  = 1'b0;
            m_t    = 0;
            m_win  = 0;
            m_next = 0;
        end else if (!m_act) begin
            if (bus.req != '0) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    int c;
                    c = (m_next + k) % NUM_REQ;
                    if (bus.req[c]) begin
                        m_win = c;
                        break;
                    end
                end
                m_bx  = int'(bus.req_x[8*m_win +: 8]);
                m_by  = int'(bus.req_y[7*m_win +: 7]);
                m_col = int'(bus.req_colour[3*m_win +: 3]);
                m_act = 1'b1;
                m_t   = 0;
            end
        end else begin
            m_t++;
            if (m_t > NPIX) begin
                m_act  = 1'b0;
                m_next = (m_win + 1) % NUM_REQ;
            end
        end
    end

    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            int px, py;
            bit show;
            px   = m_bx + (m_t % BOX_W);
            py   = m_by + (m_t / BOX_W);
            show = m_act && (m_t < NPIX) && (px < SCREEN_W) && (py < SCREEN_H);
            check("m_grant", bus.grant, (m_act && m_t < NPIX) ? (32'd1 << m_win) : 32'd0);
            check("m_done",  bus.done,  (m_act && m_t == NPIX) ? (32'd1 << m_win) : 32'd0);
            check("m_busy",  bus.busy,  m_act);
            check("m_plot",  bus.vga_plot, show);
            if (show) begin
                check("m_x",   bus.vga_x, px);
                check("m_y",   bus.vga_y, py);
                check("m_col", bus.vga_colour, m_col);
            end
        end
    end

    int got_x[$];
    int got_y[$];

    // Steps negedge by negedge through one service started by the caller's request.
    task automatic observe(input int drop_at, input int drop_field, input logic [7:0] new_x,
                           output logic [NUM_REQ-1:0] g1, output int n_plot,
                           output int done_step, output logic [NUM_REQ-1:0] done_val,
                           output logic busy_end);
        n_plot    = 0;
        done_step = -1;
        done_val  = '0;
        g1        = '0;
        busy_end  = 1'b1;
        got_x.delete();
        got_y.delete();
        for (int s = 1; s <= 20; s++) begin
            @(negedge CLOCK_50);
            if (s == 1) g1 = bus.grant;
            if (bus.vga_plot) begin
                n_plot++;
                got_x.push_back(int'(bus.vga_x));
                got_y.push_back(int'(bus.vga_y));
            end
            if (bus.done != '0 && done_step < 0) begin
                done_step = s;
                done_val  = bus.done;
            end
            if (s == 18) busy_end = bus.busy;
            if (s == drop_at) begin
                bus.req = '0;
                bus.req_x[8*drop_field +: 8] = new_x;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        #2 reset = 1'b1;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    initial begin
        logic [NUM_REQ-1:0] g1, dv;
        int np, ds;
        logic be;
        logic [NUM_REQ-1:0] exp_order[5];
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;

        bus.req = '0; bus.req_x = '0; bus.req_y = '0; bus.req_colour = '0;
        repeat (2) @(negedge CLOCK_50);
        reset  = 1'b0;
        chk_en = 1'b1;
        check("rst_grant", bus.grant, 0);
        check("rst_done",  bus.done, 0);
        check("rst_busy",  bus.busy, 0);
        check("rst_plot",  bus.vga_plot, 0);
        check("rst_x",     bus.vga_x, 0);

        // 1: single rectangle at (80,50), colour 2
        bus.req_x[7:0] = 8'd80; bus.req_y[6:0] = 7'd50; bus.req_colour[2:0] = 3'b010;
        bus.req = 4'b0001;
        observe(1, 0, 8'd80, g1, np, ds, dv, be);
        check("t1_grant", g1, 4'b0001);
        check("t1_nplot", np, 16);
        for (int k = 0; k < got_x.size(); k++) begin
            check("t1_px_x", got_x[k], 80 + k % 4);
            check("t1_px_y", got_y[k], 50 + k / 4);
        end
        check("t1_done_step", ds, 17);
        check("t1_done_val", dv, 4'b0001);
        check("t1_busy_end", be, 0);

        // 2: all four request continuously, starting from a fresh pointer
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_x[8*i +: 8] = 8'(10 * i); bus.req_y[7*i +: 7] = 7'(5 * i);
            bus.req_colour[3*i +: 3] = 3'(i + 1);
        end
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int waited, held;
            waited = 0;
            while (bus.grant == '0 && waited < 40) begin
                @(negedge CLOCK_50);
                waited++;
            end
            check("t2_grant_timeout", waited < 40, 1);
            check("t2_order", bus.grant, exp_order[k]);
            held = 0;
            while (bus.grant != '0 && held < 40) begin
                @(negedge CLOCK_50);
                held++;
            end
            check("t2_grant_len", held, 16);
        end
        bus.req = '0;
        repeat (20) @(negedge CLOCK_50);

        // 3: rectangle straddling the bottom-right corner
        bus.req_x[15:8] = 8'd158; bus.req_y[13:7] = 7'd118; bus.req_colour[5:3] = 3'b111;
        bus.req = 4'b0010;
        observe(1, 1, 8'd158, g1, np, ds, dv, be);
        check("t3_grant", g1, 4'b0010);
        check("t3_nplot", np, 4);
        for (int k = 0; k < got_x.size(); k++) begin
            check("t3_px_x", got_x[k], 158 + k % 2);
            check("t3_px_y", got_y[k], 118 + k / 2);
        end
        check("t3_done_step", ds, 17);
        check("t3_done_val", dv, 4'b0010);

        // 4: requester 2 drops req and moves mid-draw
        bus.req_x[23:16] = 8'd20; bus.req_y[20:14] = 7'd30; bus.req_colour[8:6] = 3'b101;
        bus.req = 4'b0100;
        observe(4, 2, 8'd100, g1, np, ds, dv, be);
        check("t4_nplot", np, 16);
        for (int k = 0; k < got_x.size(); k++) begin
            check("t4_px_x", got_x[k], 20 + k % 4);
            check("t4_px_y", got_y[k], 30 + k / 4);
        end
        check("t4_done_val", dv, 4'b0100);
        check("t4_done_step", ds, 17);

        // 5: reset during the fifth pixel, pointer must restart at 0
        bus.req_x[31:24] = 8'd40; bus.req_y[27:21] = 7'd40;
        bus.req = 4'b1000;
        repeat (5) @(negedge CLOCK_50);
        check("t5_pre_plot", bus.vga_plot, 1);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_grant", bus.grant, 0);
        check("t5_rst_busy",  bus.busy, 0);
        check("t5_rst_plot",  bus.vga_plot, 0);
        check("t5_rst_x",     bus.vga_x, 0);
        check("t5_rst_y",     bus.vga_y, 0);
        check("t5_rst_col",   bus.vga_colour, 0);
        bus.req = '0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
        bus.req = 4'b1010;
        observe(1, 1, bus.req_x[15:8], g1, np, ds, dv, be);
        check("t5_first_grant", g1, 4'b0010);
        check("t5_done_val", dv, 4'b0010);

        // 6: random traffic, model checks every cycle
        for (int c = 0; c < 1500; c++) begin
            @(negedge CLOCK_50);
            if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
            bus.req_x      = 32'($urandom);
            bus.req_y      = 28'($urandom);
            bus.req_colour = 12'($urandom);
        end
        bus.req = '0;
        repeat (40) @(negedge CLOCK_50);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
